stream_pack_m: RTL
==================

STREAM_PACK_M -- requirements
Module: stream_pack_m

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the input beat width in bits (>=1).
REQ-002 The module SHALL have parameter RATIO, default 4, giving input beats per output word (>=2).
REQ-003 The module SHALL have port clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 The module SHALL have port valid_src  input  1  input beat valid.
REQ-006 The module SHALL have port ready_src  output  1  input beat accepted when high together with valid_src.
REQ-007 The module SHALL have port src_data  input  DATA_W  input beat payload.
REQ-008 The module SHALL have port src_last  input  1  final beat of packet.
REQ-009 The module SHALL have port valid_dst  output  1  output word valid.
REQ-010 The module SHALL have port ready_dst  input  1  output word accepted when high together with valid_dst.
REQ-011 The module SHALL have port dst_data  output  DATA_W*RATIO  packed output word.
REQ-012 The module SHALL have port dst_keep  output  RATIO  per-lane occupancy, bit i for lane i.
REQ-013 The module SHALL have port dst_last  output  1  word closes a packet.

Function
REQ-014 Lane i SHALL be bits [i*DATA_W +: DATA_W]; the first beat of a word SHALL go to lane 0 (LSB).
REQ-015 An input handshake SHALL be valid_src && ready_src; an output handshake SHALL be valid_dst && ready_dst.
REQ-016 The accumulator SHALL hold a lane counter of clog2(RATIO) bits plus lane data, keep and last, and SHALL have two states: FILL (collecting) and HELD (complete word waiting).
REQ-017 In FILL, each accepted beat SHALL be written to lane cnt, set keep[cnt], and increment cnt.
REQ-018 A beat SHALL complete the word when cnt==RATIO-1 or src_last==1; that beat SHALL also be stored, last SHALL be set to src_last, cnt SHALL return to 0, and the state SHALL become HELD.
REQ-019 Lanes not written in a short word SHALL be driven as zero and their keep bits SHALL be 0.
REQ-020 The output register SHALL be a single entry with a full flag; valid_dst SHALL equal full.
REQ-021 A HELD word SHALL move to the output register in any cycle where !full || ready_dst.
REQ-022 When a HELD word moves while an output handshake occurs in the same cycle, full SHALL stay 1 and the new word SHALL replace the old one with no bubble.
REQ-023 full SHALL clear on an output handshake with no HELD word moving in.
REQ-024 ready_src SHALL be high when the state is FILL, or the state is HELD and the word moves this cycle.
REQ-025 ready_src SHALL NOT depend on valid_src or src_data.
REQ-026 A word accepted into lane 0 in the same cycle a HELD word moves out SHALL start a new FILL cleanly, with no lane data or keep bits carried over.
REQ-027 Latency SHALL be: completing beat accepted at cycle T gives valid_dst at T+2 when the output is empty or draining.
REQ-028 Sustained throughput SHALL be 1 beat per cycle while ready_dst stays high.
REQ-029 dst_data, dst_keep and dst_last SHALL stay stable while valid_dst && !ready_dst.

Reset
REQ-030 On rst_n low, the block SHALL immediately clear cnt, state (FILL), full, all accumulator data, keep and last, and drive valid_dst=0, dst_data=0, dst_keep=0 and dst_last=0.
REQ-031 A reset asserted mid-packet or mid-stall SHALL discard all partial and pending words.
REQ-032 After rst_n deasserts, ready_src SHALL be 1 at the first clock.

Verification (DATA_W=8, RATIO=4)
REQ-033 Full word: with ready_dst=1, send 0x11, 0x22, 0x33, 0x44 (last on 4th) -> dst_data=0x44332211, dst_keep=1111, dst_last=1, valid_dst for one cycle, 2 cycles after the 4th accept.
REQ-034 Short packet: send 0xAA, 0xBB (last) -> dst_data=0x0000BBAA, dst_keep=0011, dst_last=1.
REQ-035 Backpressure: hold ready_dst=0 and offer 0x01..0x0C with no last -> exactly 8 beats accepted, then ready_src=0; release ready_dst -> words 0x04030201, 0x08070605, 0x0C0B0A09 in order, dst_last=0, no loss or duplication.
REQ-036 Back-to-back single-beat packets: 0x5A(last), 0x5B(last), 0x5C(last) every cycle with ready_dst=1 -> three consecutive words, each dst_keep=0001, dst_last=1, valid_dst high 3 consecutive cycles.
REQ-037 Stall stability: hold ready_dst=0 for 5 cycles with a word pending -> dst outputs unchanged throughout.
REQ-038 Reset mid-operation: pulse rst_n low after 2 beats of a word and with full=1 -> all outputs 0; then send 0x01..0x04 -> dst_data=0x04030201, dst_keep=1111, with no residue from before reset.

Source files
------------

// File: rtl/stream_pack_m_if.sv
// Handshake bundle for the beat-to-word packer: narrow source side, wide destination side.
interface stream_pack_m_if #(
    parameter int DATA_W = 8,
    parameter int RATIO  = 4
);
    logic                     valid_src;
    logic                     ready_src;
    logic [DATA_W-1:0]        src_data;
    logic                     src_last;
    logic                     valid_dst;
    logic                     ready_dst;
    logic [DATA_W*RATIO-1:0]  dst_data;
    logic [RATIO-1:0]         dst_keep;
    logic                     dst_last;

    // Producer of beats and consumer of words (e.g. a testbench or surrounding fabric).
    modport master (
        output valid_src, src_data, src_last, ready_dst,
        input  ready_src, valid_dst, dst_data, dst_keep, dst_last
    );

    // The packer itself.
    modport slave (
        input  valid_src, src_data, src_last, ready_dst,
        output ready_src, valid_dst, dst_data, dst_keep, dst_last
    );
endinterface

// File: rtl/stream_pack_m.sv
// Packs RATIO narrow beats into one wide word; src_last closes a short word early.
// A FILL/HELD accumulator feeds a single-entry output register that can be
// refilled in the same cycle it drains, so a steady stream runs at one beat per cycle.
module stream_pack_m #(
    parameter int DATA_W = 8,
    parameter int RATIO  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_pack_m_if.slave bus
);
    localparam int CNT_W  = $clog2(RATIO);
    localparam int WORD_W = DATA_W * RATIO;

    typedef enum logic {
        FILL = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_W-1:0]   acc_data;
    logic [RATIO-1:0]    acc_keep;
    logic                acc_last;
    logic [WORD_W-1:0]   acc_data_next;
    logic [RATIO-1:0]    acc_keep_next;
    logic [WORD_W-1:0]   out_data;
    logic [RATIO-1:0]    out_keep;
    logic                out_last;
    logic                full;
    logic                move;
    logic                ready;
    logic                accept;
    logic                complete;

    // A held word leaves when the output slot is free or draining; the source is
    // only blocked while a complete word is stuck behind a stalled output.
    always_comb begin
        move  = (state == HELD) && (!full || bus.ready_dst);
        ready = (state == FILL) || move;
    end

    assign accept   = bus.valid_src && ready;
    assign complete = accept && ((cnt == CNT_W'(RATIO - 1)) || bus.src_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a completing beat always lands in HELD, even while the previous word moves out.
    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (complete) state_next = HELD;
            HELD:    if (move) state_next = complete ? HELD : FILL;
            default: state_next = FILL;
        endcase
    end

    // Lane insert: a held word is being handed off, so the new word starts from an empty accumulator.
    always_comb begin
        acc_data_next = (state == HELD) ? '0 : acc_data;
        acc_keep_next = (state == HELD) ? '0 : acc_keep;
        if (accept) begin
            for (int i = 0; i < RATIO; i++) begin
                if (cnt == CNT_W'(i)) begin
                    acc_data_next[i*DATA_W +: DATA_W] = bus.src_data;
                    acc_keep_next[i]                  = 1'b1;
                end
            end
        end
    end

    // Accumulator and lane counter update on accepted beats and on hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            acc_last <= 1'b0;
        end else begin
            if (complete) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + CNT_W'(1);
            end
            if ((state == FILL && accept) || move) begin
                acc_data <= acc_data_next;
                acc_keep <= acc_keep_next;
                acc_last <= complete ? bus.src_last : 1'b0;
            end
        end
    end

    // Output slot: load on hand-off (replacing a word that drains the same cycle), empty on a plain drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            out_data <= '0;
            out_keep <= '0;
            out_last <= 1'b0;
        end else if (move) begin
            full     <= 1'b1;
            out_data <= acc_data;
            out_keep <= acc_keep;
            out_last <= acc_last;
        end else if (bus.ready_dst) begin
            full <= 1'b0;
        end
    end

    assign bus.ready_src = ready;
    assign bus.valid_dst = full;
    assign bus.dst_data  = out_data;
    assign bus.dst_keep  = out_keep;
    assign bus.dst_last  = out_last;
endmodule
